jt51_chacc: RTL and testbench
=============================

Name: jt51_chacc

Overview:
- Per-frame output accumulator directly downstream of the operator pipeline.
- Receives one signed 14-bit operator sample per cen cycle in slot order.
- Decides from the channel's connection algorithm whether each slot is a carrier.
- Sums carriers into left/right accumulators, routed by the channel's RL enables.
- Once per 32-slot frame, saturates the sums and presents a registered stereo sample to the DAC/mixer path.

Parameters:
- ACCW, 19, accumulator width in bits. Must hold 32 × ±8192 without overflow; minimum 19.
- OUTW, 16, output sample width in bits; saturation bounds are derived from it.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable; all state advances only when cen=1
- zero  in  1  frame marker; high on the cen cycle whose op_XVII is slot 0
- op_XVII  in  14  signed operator output for the current slot
- con_XVII  in  3  connection algorithm of the current slot's channel, aligned with op_XVII
- rl_XVII  in  2  channel output enables; bit0 = left, bit1 = right; aligned with op_XVII
- left  out  OUTW  signed saturated left sample
- right  out  OUTW  signed saturated right sample
- sample  out  1  high for exactly one cen cycle when left/right update

Behaviour:
- Reset (rst_n=0, asynchronous):
  - left=0, right=0, sample=0.
  - Both accumulators = 0, slot counter = 0, frame_valid = 0.
- cen=0: all registers hold; sample holds its value.
- Slot counter (5 bits):
  - On each cen cycle, slot = zero ? 0 : slot_q+1, wrapping 31→0.
  - The slot value applies to the current input.
- Slot map: 0-7 = M1 ch0-7, 8-15 = M2, 16-23 = C1, 24-31 = C2.
- Carrier decision by operator group:
  - C2: always a carrier.
  - C1: carrier when con ≥ 4.
  - M2: carrier when con ≥ 5.
  - M1: carrier when con = 7.
- Contribution:
  - contrib = sign-extend(op_XVII) to ACCW if carrier, else 0.
  - Left adds contrib only if rl_XVII[0]; right adds contrib only if rl_XVII[1].
- Accumulate, per side:
  - slot = 0: acc <= contrib (fresh start; the previous frame's sum is not carried over).
  - slot = 1..30: acc <= acc + contrib.
  - slot = 31: output <= sat(acc + contrib); acc <= 0; sample <= frame_valid.
  - On any other cen cycle, sample <= 0.
- frame_valid:
  - Set on a cen cycle with zero=1.
  - Cleared when zero=1 arrives while the counter is not already expecting slot 0 (i.e. slot_q ≠ 31 — a mid-frame resync).
  - After a mid-frame resync it is set again at that same slot 0, so the frame that starts there completes normally.
  - The truncated frame is discarded: left/right keep their previous values and sample stays 0.
  - Before the first zero after reset, no sample is emitted.
- Saturation:
  - sat(x) = 2^(OUTW-1)-1 if x > 2^(OUTW-1)-1.
  - sat(x) = -2^(OUTW-1) if x < -2^(OUTW-1).
  - Otherwise, x truncated to OUTW bits.
- Latency: left/right/sample become visible at the clk edge of the slot-31 cen cycle; they are registered, with no combinational path from op_XVII.
- zero coinciding with slot_q=31: normal wrap, no resync effect.
- Arithmetic is full two's-complement at ACCW bits; there is no intermediate wrap.

Test Plan:
- Reset mid-frame with rst_n low for 3 clk, then release with zero pulse and cen=1 every clk → left=right=0 and sample=0 until the first full frame completes.
- con=7, rl=11, op=100 for all 32 slots → at slot 31: left=right=3200, sample high for one cen cycle.
- con=0, rl=01, op=100 all slots → left=800 (C2 only), right=0.
- con=4, rl=10, op=-50 → right=-800 (C1+C2, 16 slots); left=0.
- con=7, rl=11, op=8191 all slots → left=right=32767. Repeat with op=-8192 → -32768.
- Frame with cen toggling 1/0 each clk → same sums as the continuous case, sample asserted on the slot-31 cen cycle only.
- zero re-asserted at slot 12 → no sample for the truncated frame, outputs unchanged; the following full frame produces correct sums.

Source files
------------

// File: rtl/jt51_chacc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jt51_chacc_if: operator-sample stream into, and stereo sample out of, the  |
// | channel accumulator.                                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface jt51_chacc_if #(
    parameter int OUTW = 16
);
    logic                   cen;
    logic                   zero;
    logic signed [13:0]     op_XVII;
    logic        [2:0]      con_XVII;
    logic        [1:0]      rl_XVII;
    logic signed [OUTW-1:0] left;
    logic signed [OUTW-1:0] right;
    logic                   sample;

    modport master (
        output cen, zero, op_XVII, con_XVII, rl_XVII,
        input  left, right, sample
    );

    modport slave (
        input  cen, zero, op_XVII, con_XVII, rl_XVII,
        output left, right, sample
    );
endinterface
`default_nettype wire

// File: rtl/jt51_chacc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jt51_chacc: sums carrier operator samples per 32-slot frame into a         |
// | saturated, registered left/right sample.                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module jt51_chacc #(
    parameter int ACCW = 19,
    parameter int OUTW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    jt51_chacc_if.slave   bus
);

    localparam logic signed [ACCW-1:0] c_pos_lim = ACCW'((2 ** (OUTW - 1)) - 1);
    localparam logic signed [ACCW-1:0] c_neg_lim = ~c_pos_lim;

    function automatic logic signed [OUTW-1:0] sat(input logic signed [ACCW-1:0] x);
        if (x > c_pos_lim)
            return c_pos_lim[OUTW-1:0];
        else if (x < c_neg_lim)
            return c_neg_lim[OUTW-1:0];
        else
            return x[OUTW-1:0];
    endfunction

    logic        [4:0]      slot_q,  slot_d;
    logic                   fv_q,    fv_d;
    logic signed [ACCW-1:0] acc_l_q, acc_l_d;
    logic signed [ACCW-1:0] acc_r_q, acc_r_d;
    logic signed [OUTW-1:0] left_q,  left_d;
    logic signed [OUTW-1:0] right_q, right_d;
    logic                   sample_q, sample_d;

    logic                   w_carrier;
    logic signed [ACCW-1:0] w_contrib;
    logic signed [ACCW-1:0] w_sum_l;
    logic signed [ACCW-1:0] w_sum_r;

    always_comb begin
        slot_d = bus.zero ? 5'd0 : slot_q + 5'd1;

        // slot[4:3] selects the operator group: M1, M2, C1, C2
        unique case (slot_d[4:3])
            2'd0:    w_carrier = (bus.con_XVII == 3'd7);
            2'd1:    w_carrier = (bus.con_XVII >= 3'd5);
            2'd2:    w_carrier = (bus.con_XVII >= 3'd4);
            default: w_carrier = 1'b1;
        endcase

        w_contrib = w_carrier ? {{(ACCW-14){bus.op_XVII[13]}}, bus.op_XVII} : '0;

        w_sum_l = ((slot_d == 5'd0) ? '0 : acc_l_q) + (bus.rl_XVII[0] ? w_contrib : '0);
        w_sum_r = ((slot_d == 5'd0) ? '0 : acc_r_q) + (bus.rl_XVII[1] ? w_contrib : '0);

        // A mid-frame zero clears and immediately re-arms the flag for the new
        // frame, so its net effect is the same as an aligned zero.
        fv_d = fv_q | bus.zero;

        if (slot_d == 5'd31) begin
            acc_l_d  = '0;
            acc_r_d  = '0;
            left_d   = sat(w_sum_l);
            right_d  = sat(w_sum_r);
            sample_d = fv_q;
        end else begin
            acc_l_d  = w_sum_l;
            acc_r_d  = w_sum_r;
            left_d   = left_q;
            right_d  = right_q;
            sample_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            fv_q     <= 1'b0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            left_q   <= '0;
            right_q  <= '0;
            sample_q <= 1'b0;
        end else if (bus.cen) begin
            slot_q   <= slot_d;
            fv_q     <= fv_d;
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            left_q   <= left_d;
            right_q  <= right_d;
            sample_q <= sample_d;
        end
    end

    assign bus.left   = left_q;
    assign bus.right  = right_q;
    assign bus.sample = sample_q;

endmodule
`default_nettype wire

// File: tb/tb_jt51_chacc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_jt51_chacc: randomized and directed frames against a frame-level model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_jt51_chacc;
    localparam int OUTW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jt51_chacc_if #(.OUTW(OUTW)) bus ();

    jt51_chacc #(.ACCW(19), .OUTW(OUTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_slot, m_suml, m_sumr, m_left, m_right;
    bit m_fv, m_sample;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_carrier(input int slot, input int con);
        case (slot / 8)
            0:       return con == 7;
            1:       return con >= 5;
            2:       return con >= 4;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int sat(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_reset();
        m_slot = 0; m_suml = 0; m_sumr = 0;
        m_left = 0; m_right = 0; m_fv = 0; m_sample = 0;
    endtask

    task automatic model_step(input bit z, input int op, input int con, input int rl);
        int s;
        s = z ? 0 : (m_slot + 1) % 32;
        if (z) m_fv = 1;
        if (s == 0) begin
            m_suml = 0;
            m_sumr = 0;
        end
        if (is_carrier(s, con)) begin
            if (rl[0]) m_suml += op;
            if (rl[1]) m_sumr += op;
        end
        if (s == 31) begin
            m_left   = sat(m_suml);
            m_right  = sat(m_sumr);
            m_sample = m_fv;
        end else begin
            m_sample = 0;
        end
        m_slot = s;
    endtask

    task automatic step(input bit c, input bit z, input int op, input int con,
                        input int rl, input string tag);
        bus.cen      = c;
        bus.zero     = z;
        bus.op_XVII  = op[13:0];
        bus.con_XVII = con[2:0];
        bus.rl_XVII  = rl[1:0];
        @(posedge clk);
        #1;
        if (c) model_step(z, op, con, rl);
        chk({tag, "_left"},   $signed(bus.left),  m_left);
        chk({tag, "_right"},  $signed(bus.right), m_right);
        chk({tag, "_sample"}, {31'd0, bus.sample}, {31'd0, m_sample});
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'($urandom), int'($urandom_range(0, 16383)) - 8192,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), tag);
    endtask

    task automatic run_frame(input int op, input int con, input int rl,
                             input bit gap, input string tag);
        for (int s = 0; s < 32; s++) begin
            step(1'b1, s == 0, op, con, rl, tag);
            if (gap && s != 31) idle(tag);
        end
    endtask

    function automatic int rand_op();
        if ($urandom_range(0, 1) == 1)
            return int'($urandom_range(0, 16383)) - 8192;
        return int'($urandom_range(0, 600)) - 300;
    endfunction

    initial begin
        rst_n        = 1'b0;
        bus.cen      = 1'b0;
        bus.zero     = 1'b0;
        bus.op_XVII  = '0;
        bus.con_XVII = '0;
        bus.rl_XVII  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_left",   $signed(bus.left),  0);
        chk("rst_right",  $signed(bus.right), 0);
        chk("rst_sample", {31'd0, bus.sample}, 0);
        rst_n = 1'b1;

        // No zero yet: counter runs but no sample may be flagged.
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 100, 7, 3, "nozero");

        // Mid-frame reset, then restart with a zero pulse and cen every clk.
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 100, 7, 3, "prerst");
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 100, 7, 3, "inrst");
        rst_n = 1'b1;

        run_frame(100, 7, 3, 1'b0, "c7");
        chk("c7_left_abs",   $signed(bus.left),  3200);
        chk("c7_right_abs",  $signed(bus.right), 3200);
        chk("c7_sample_abs", {31'd0, bus.sample}, 1);

        run_frame(100, 0, 1, 1'b0, "c0");
        chk("c0_left_abs",  $signed(bus.left),  800);
        chk("c0_right_abs", $signed(bus.right), 0);

        run_frame(-50, 4, 2, 1'b0, "c4");
        chk("c4_left_abs",  $signed(bus.left),  0);
        chk("c4_right_abs", $signed(bus.right), -800);

        run_frame(8191, 7, 3, 1'b0, "satp");
        chk("satp_left_abs",  $signed(bus.left),  32767);
        chk("satp_right_abs", $signed(bus.right), 32767);

        run_frame(-8192, 7, 3, 1'b0, "satn");
        chk("satn_left_abs",  $signed(bus.left),  -32768);
        chk("satn_right_abs", $signed(bus.right), -32768);

        run_frame(100, 7, 3, 1'b1, "gap");
        chk("gap_left_abs",   $signed(bus.left), 3200);
        chk("gap_sample_abs", {31'd0, bus.sample}, 1);
        idle("gaphold");

        // Truncated frame: zero re-asserted where slot 12 would be.
        for (int s = 0; s < 12; s++) step(1'b1, s == 0, 200, 7, 3, "trunc");
        chk("trunc_left_abs",   $signed(bus.left), 3200);
        chk("trunc_sample_abs", {31'd0, bus.sample}, 0);
        run_frame(7, 0, 3, 1'b0, "resync");
        chk("resync_left_abs",   $signed(bus.left),  56);
        chk("resync_right_abs",  $signed(bus.right), 56);
        chk("resync_sample_abs", {31'd0, bus.sample}, 1);

        for (int f = 0; f < 24; f++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 31)) : 32;
            for (int s = 0; s < len; s++) begin
                step(1'b1, s == 0, rand_op(), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)), "rnd");
                if ($urandom_range(0, 3) == 0) idle("rndgap");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
